// File: rtl/vga_fb_scanner.sv
// vga_fb_scanner: sweeps a VGA raster, fetches one framebuffer word per cell and
// expands its low byte (RGB332) into a CELL x CELL block of pixels.
// Pipeline: stage 0 counters, stage 1 address/flags, stage 2 memory read, stage 3 pins.
module vga_fb_scanner #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       FB_W      = 32,
  parameter int unsigned       FB_H      = 24,
  parameter int unsigned       CELL      = 20,
  parameter int unsigned       H_VIS     = 640,
  parameter int unsigned       H_FP      = 16,
  parameter int unsigned       H_SYNC    = 96,
  parameter int unsigned       H_BP      = 48,
  parameter int unsigned       V_VIS     = 480,
  parameter int unsigned       V_FP      = 10,
  parameter int unsigned       V_SYNC    = 2,
  parameter int unsigned       V_BP      = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic              hsync,
  output logic              vsync,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              video_on,
  output logic              frame_start
);

  localparam int unsigned H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOT);
  localparam int unsigned VW       = $clog2(V_TOT);
  localparam int unsigned HS_BEG   = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_BEG + H_SYNC - 1;
  localparam int unsigned VS_BEG   = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_BEG + V_SYNC - 1;
  localparam int unsigned CXW      = $clog2(CELL + 1);
  localparam int unsigned COLW     = $clog2(FB_W + 1);
  localparam int unsigned RBW      = $clog2(FB_W * FB_H + 1);
  localparam int unsigned ROW_LAST = FB_W * (FB_H - 1);

  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic [CXW-1:0]  cx;
  logic [COLW-1:0] col;
  logic [CXW-1:0]  cy;
  logic [RBW-1:0]  row_base;

  logic hs_s1, vs_s1, act_s1, sof_s1;
  logic hs_s2, vs_s2, act_s2, sof_s2;

  logic h_last_c, v_last_c, h_vis_c, v_vis_c, vis_c, hs_win_c, vs_win_c, sof_c;
  logic [23:0] unused_data_c;

  // Stage-0 decode of the raster position
  assign h_last_c = (h_cnt == HW'(H_TOT - 1));
  assign v_last_c = (v_cnt == VW'(V_TOT - 1));
  assign h_vis_c  = (h_cnt < HW'(H_VIS));
  assign v_vis_c  = (v_cnt < VW'(V_VIS));
  assign vis_c    = h_vis_c && v_vis_c;
  assign hs_win_c = (h_cnt >= HW'(HS_BEG)) && (h_cnt <= HW'(HS_END));
  assign vs_win_c = (v_cnt >= VW'(VS_BEG)) && (v_cnt <= VW'(VS_END));
  assign sof_c    = (h_cnt == '0) && (v_cnt == '0);

  // Only the colour byte of the framebuffer word is displayed
  assign unused_data_c = mem_data[31:8];

  // Raster counters: h wraps at end of line, v advances on h wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last_c) begin
        h_cnt <= '0;
        v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Horizontal cell tracking: cx sub-counter and column index, cleared at line end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx  <= '0;
      col <= '0;
    end else if (pix_en) begin
      if (h_last_c) begin
        cx  <= '0;
        col <= '0;
      end else if (h_vis_c) begin
        if (cx == CXW'(CELL - 1)) begin
          cx  <= '0;
          col <= (col == COLW'(FB_W - 1)) ? '0 : col + COLW'(1);
        end else begin
          cx <= cx + CXW'(1);
        end
      end
    end
  end

  // Vertical cell tracking: cy sub-counter and row base address, cleared at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cy       <= '0;
      row_base <= '0;
    end else if (pix_en && h_last_c) begin
      if (v_last_c) begin
        cy       <= '0;
        row_base <= '0;
      end else if (v_vis_c) begin
        if (cy == CXW'(CELL - 1)) begin
          cy       <= '0;
          row_base <= (row_base == RBW'(ROW_LAST)) ? '0 : row_base + RBW'(FB_W);
        end else begin
          cy <= cy + CXW'(1);
        end
      end
    end
  end

  // Stage 1: issue the cell address and register raw sync/active/sof flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= BASE_ADDR;
      hs_s1    <= 1'b0;
      vs_s1    <= 1'b0;
      act_s1   <= 1'b0;
      sof_s1   <= 1'b0;
    end else if (pix_en) begin
      if (vis_c) begin
        mem_addr <= BASE_ADDR + ADDR_W'(row_base) + ADDR_W'(col);
      end
      hs_s1  <= hs_win_c;
      vs_s1  <= vs_win_c;
      act_s1 <= vis_c;
      sof_s1 <= sof_c;
    end
  end

  // Stage 2: delay flags while the memory returns the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s2  <= 1'b0;
      vs_s2  <= 1'b0;
      act_s2 <= 1'b0;
      sof_s2 <= 1'b0;
    end else if (pix_en) begin
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
      act_s2 <= act_s1;
      sof_s2 <= sof_s1;
    end
  end

  // Stage 3: output registers, colour blanked outside the visible area
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else if (pix_en) begin
      hsync                <= ~hs_s2;
      vsync                <= ~vs_s2;
      video_on             <= act_s2;
      frame_start          <= sof_s2;
      {red, green, blue}   <= act_s2 ? mem_data[7:0] : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanner.sv
// Bench for vga_fb_scanner: a full-size instance probed at fixed ticks from a table,
// and a reduced-raster instance (BASE_ADDR=1000) checked pixel-by-pixel by a scoreboard.
module tb_vga_fb_scanner;

  localparam int S_HVIS = 64, S_HFP = 4, S_HSYNC = 8, S_HBP = 4;
  localparam int S_HTOT = S_HVIS + S_HFP + S_HSYNC + S_HBP;
  localparam int S_VVIS = 48, S_VFP = 2, S_VSYNC = 2, S_VBP = 3;
  localparam int S_VTOT = S_VVIS + S_VFP + S_VSYNC + S_VBP;
  localparam int S_CELL = 4, S_FBW = 16, S_FBH = 12, S_BASE = 1000;
  localparam logic [11:0] RST_VAL = 12'hC00;  // hs=1 vs=1 vo=0 fs=0 rgb=0

  typedef struct { int h; int v; logic [11:0] val; } exp_t;
  typedef struct { int tick; logic hs; logic vo; logic fs; logic [7:0] rgb; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b1;
  int   en_mode = 0;
  logic mem_ff = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ftick = 0;

  logic [31:0] f_addr, f_data;
  logic        f_hs, f_vs, f_vo, f_fs;
  logic [2:0]  f_red, f_green;
  logic [1:0]  f_blue;
  logic [31:0] s_addr, s_data;
  logic        s_hs, s_vs, s_vo, s_fs;
  logic [2:0]  s_red, s_green;
  logic [1:0]  s_blue;
  logic [7:0]  f_rgb;
  logic [11:0] s_out;
  logic [31:0] s_max = 32'd0, s_min = 32'hFFFF_FFFF, f_max = 32'd0;

  assign f_rgb = {f_red, f_green, f_blue};
  assign s_out = {s_hs, s_vs, s_vo, s_fs, s_red, s_green, s_blue};

  vga_fb_scanner u_full (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .mem_addr(f_addr), .mem_data(f_data),
    .hsync(f_hs), .vsync(f_vs), .red(f_red), .green(f_green), .blue(f_blue),
    .video_on(f_vo), .frame_start(f_fs)
  );

  vga_fb_scanner #(
    .BASE_ADDR(32'd1000), .FB_W(S_FBW), .FB_H(S_FBH), .CELL(S_CELL),
    .H_VIS(S_HVIS), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
    .V_VIS(S_VVIS), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .mem_addr(s_addr), .mem_data(s_data),
    .hsync(s_hs), .vsync(s_vs), .red(s_red), .green(s_green), .blue(s_blue),
    .video_on(s_vo), .frame_start(s_fs)
  );

  always #5 clk = ~clk;

  // Memory read ports: word k holds k[7:0] with junk above; data holds while pix_en=0
  always @(posedge clk) begin
    if (pix_en) begin
      f_data <= {24'hC3C3C3, f_addr[7:0]};
      s_data <= mem_ff ? 32'hFFFF_FFFF : {24'h5A5A5A, s_addr[7:0]};
    end
  end

  // Pixel enable: every clk, or every second clk
  always @(negedge clk) pix_en = (en_mode != 0) ? ~pix_en : 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ftick <= 0;
    else if (pix_en) ftick <= ftick + 1;
  end

  // Track the range of addresses presented to the memory
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_addr > s_max) s_max = s_addr;
      if (s_addr < s_min) s_min = s_addr;
      if (f_addr > f_max) f_max = f_addr;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  function automatic logic [11:0] s_model(input int h, input int v, input logic ff);
    logic hs, vs, vo, fs;
    logic [7:0] rgb;
    int a;
    hs = !(h >= S_HVIS + S_HFP && h < S_HVIS + S_HFP + S_HSYNC);
    vs = !(v >= S_VVIS + S_VFP && v < S_VVIS + S_VFP + S_VSYNC);
    vo = (h < S_HVIS) && (v < S_VVIS);
    fs = (h == 0) && (v == 0);
    a  = S_BASE + (v / S_CELL) * S_FBW + h / S_CELL;
    rgb = !vo ? 8'h00 : (ff ? 8'hFF : a[7:0]);
    return {hs, vs, vo, fs, rgb};
  endfunction

  // Scoreboard for the reduced raster: push expected on each tick, pop 3 ticks later
  int sh = 0, sv = 0, sframe = 0;
  exp_t sq[$];
  logic [43:0] prev_s;

  always @(posedge clk) begin : sb
    logic en;
    exp_t e;
    en = pix_en;
    #1;
    if (!rst_n) begin
      sh = 0; sv = 0;
      sq.delete();
      e.h = -1; e.v = -1; e.val = RST_VAL;
      sq.push_back(e);
      sq.push_back(e);
    end else if (en) begin
      e.h = sh; e.v = sv; e.val = s_model(sh, sv, mem_ff);
      sq.push_back(e);
      // flip the memory to all-ones for the second frame, switching inside v-blank
      if (sh == 0 && sv == S_VVIS + S_VFP) mem_ff = (sframe == 0);
      if (sh == S_HTOT - 1) begin
        sh = 0;
        if (sv == S_VTOT - 1) begin sv = 0; sframe++; end
        else sv++;
      end else begin
        sh++;
      end
      e = sq.pop_front();
      chk($sformatf("pixel h=%0d v=%0d", e.h, e.v), s_out, e.val);
    end else begin
      chk("hold on pix_en=0", {s_out, s_addr}, prev_s);
    end
    prev_s = {s_out, s_addr};
  end

  initial begin : watchdog
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: time limit reached before end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : main
    vec_t tbl[16];
    int guard, nf;
    int falls[3];
    logic hs_prev;

    // Full-size probes: output tick = h + 800*v + 3
    tbl[0]  = '{1,     1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{2,     1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{3,     1'b1, 1'b1, 1'b1, 8'h00};
    tbl[3]  = '{4,     1'b1, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{22,    1'b1, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{23,    1'b1, 1'b1, 1'b0, 8'h01};
    tbl[6]  = '{28,    1'b1, 1'b1, 1'b0, 8'h01};
    tbl[7]  = '{658,   1'b1, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{659,   1'b0, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{754,   1'b0, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{755,   1'b1, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{822,   1'b1, 1'b1, 1'b0, 8'h00};
    tbl[12] = '{823,   1'b1, 1'b1, 1'b0, 8'h01};
    tbl[13] = '{1459,  1'b0, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{16002, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{16003, 1'b1, 1'b1, 1'b0, 8'h20};

    repeat (4) @(negedge clk);
    chk("reset full outputs", {f_hs, f_vs, f_vo, f_fs, f_rgb}, RST_VAL);
    chk("reset small outputs", s_out, RST_VAL);
    chk("reset full mem_addr", f_addr, 0);
    chk("reset small mem_addr", s_addr, S_BASE);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      guard = 0;
      while (ftick < tbl[i].tick && guard < 20000) begin
        @(negedge clk);
        guard++;
      end
      if (ftick != tbl[i].tick) begin
        n_chk++; n_fail++;
        $display("FAIL full tick %0d: reached tick %0d instead", tbl[i].tick, ftick);
      end else begin
        chk($sformatf("full tick %0d {hs,vo,fs,rgb}", tbl[i].tick),
            {f_hs, f_vo, f_fs, f_rgb}, {tbl[i].hs, tbl[i].vo, tbl[i].fs, tbl[i].rgb});
      end
    end

    // Half-rate pixel enable: hsync period doubles in clocks
    en_mode = 1;
    nf = 0; guard = 0; hs_prev = s_hs;
    while (nf < 3 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (hs_prev && !s_hs) begin falls[nf] = cyc; nf++; end
      hs_prev = s_hs;
    end
    if (nf < 3) begin
      n_chk++; n_fail++;
      $display("FAIL hsync period: saw %0d falling edges, required 3", nf);
    end else begin
      chk("hsync period in clks", falls[2] - falls[1], 2 * S_HTOT);
    end
    repeat (2 * S_HTOT * S_VTOT) @(negedge clk);

    // Reset pulse in the middle of a frame
    en_mode = 0;
    guard = 0;
    while (!(sh == 30 && sv == 20) && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (!(sh == 30 && sv == 20)) begin
      n_chk++; n_fail++;
      $display("FAIL mid-frame position: reached h=%0d v=%0d, required h=30 v=20", sh, sv);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset small outputs", s_out, RST_VAL);
    chk("mid reset small mem_addr", s_addr, S_BASE);
    chk("mid reset full outputs", {f_hs, f_vs, f_vo, f_fs, f_rgb}, RST_VAL);
    chk("mid reset full mem_addr", f_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("frame_start tick %0d after release", k), {s_fs, f_fs},
          (k == 3) ? 2'b11 : 2'b00);
    end
    repeat (200) @(negedge clk);

    chk("small max mem_addr", s_max, S_BASE + S_FBW * S_FBH - 1);
    chk("small min mem_addr", s_min, S_BASE);
    chk("full mem_addr within 767", (f_max <= 32'd767), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanner.md
Name: vga_fb_scanner

Overview:
- Display-side consumer of the data memory's second read port.
- Sweeps a 640x480@60 raster and reads one 32-bit framebuffer word per cell.
- Each word is expanded into a CELL x CELL block of RGB332 pixels, producing VGA sync and colour.
- Sits downstream of MemDatos on the SalidaVGARam path. It lets register and memory results written by the CPU pipeline be shown on screen.

Parameters:
ADDR_W, 32, width of mem_addr
BASE_ADDR, 0, word address of framebuffer cell (0,0)
FB_W, 32, framebuffer columns (cells)
FB_H, 24, framebuffer rows (cells)
CELL, 20, pixels per cell edge; FB_W*CELL must equal H_VIS and FB_H*CELL must equal V_VIS
H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (total 800)
V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525)

Ports:
clk  in  1  system clock; also clocks the memory read port
rst_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel tick; all state advances only on clk edges with pix_en=1
mem_addr  out  ADDR_W  registered word address to the memory read port
mem_data  in  32  read data; valid one clk after mem_addr changes; bits[7:0]=RRRGGGBB
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
red  out  3  pixel red
green  out  3  pixel green
blue  out  2  pixel blue
video_on  out  1  high while the output pixel is in the visible area
frame_start  out  1  one-tick pulse aligned with output pixel (0,0)

Behaviour:
- Reset (async, rst_n=0):
  - h_cnt, v_cnt, cell sub-counters, col, row_base and all pipeline stages cleared.
  - mem_addr=BASE_ADDR; hsync=1, vsync=1.
  - red/green/blue=0; video_on=0, frame_start=0.
- Reset mid-frame: all outputs go to reset values immediately. After release, scanning restarts at (h,v)=(0,0).
- Stage 0, counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it runs 0..524 and wraps to 0.
- Cell addressing (no divider):
  - cx counts 0..CELL-1 across visible pixels; col increments when cx wraps.
  - cx and col are cleared when h_cnt=799.
  - cy counts visible lines 0..CELL-1; row_base += FB_W when cy wraps.
  - cy and row_base are cleared at end of frame (h=799, v=524).
- Stage 1, tick after the counter value:
  - mem_addr <= BASE_ADDR + row_base + col while visible; otherwise mem_addr holds.
  - Raw hs, vs, active and sof (h=0 & v=0) are registered alongside.
- Stage 2: sync, active and sof are delayed one more tick. The memory returns data during this tick.
- Stage 3, output registers:
  - hsync/vsync/video_on/frame_start <= stage-2 values.
  - RGB <= mem_data[7:0] if active, else 0.
- Total latency: counter (h,v) to pins = 3 pix_en ticks, identical for sync, colour and flags.
- Sync windows:
  - hsync low for h_cnt in [656,751].
  - vsync low for v_cnt in [490,491].
- Active region: h_cnt<640 and v_cnt<480.
- pix_en=0: every register holds, including mem_addr. Memory data remains stable. pix_en may be high every clk or every Nth clk.
- Width rule: the address sum is computed modulo 2^ADDR_W. mem_data[31:8] is ignored.
- Bounds: col never exceeds FB_W-1 and row never exceeds FB_H-1. The maximum address is BASE_ADDR+FB_W*FB_H-1 (=767 at defaults).

Test Plan:
1. Reset release, pix_en=1 constantly:
   - frame_start=1 on exactly the 3rd tick after release, then every 420000 ticks.
   - hsync first falls on tick 656+3 and stays low 96 ticks; period 800.
2. Memory model: word k holds k[7:0]; BASE_ADDR=0.
   - Output pixel (h=25,v=0) shows colour 8'h01.
   - Pixel (h=0,v=20) shows 8'h20 (32).
   - Pixel (639,479) shows 8'hFF (767, low byte).
   - mem_addr never exceeds 767.
3. Blanking: mem_data forced to 8'hFF.
   - RGB=0 and video_on=0 for output h in 640..799 and v in 480..524.
   - vsync low exactly for lines 490-491.
4. pix_en asserted every 2nd clk:
   - Same pixel sequence as scenario 2.
   - Outputs change only on enabled edges; hsync period = 1600 clks.
5. rst_n pulsed low at h=300,v=200:
   - Outputs immediately go to hsync=1, vsync=1, RGB=0, video_on=0, mem_addr=BASE_ADDR.
   - After release, frame_start fires 3 ticks later.
6. BASE_ADDR=1000: pixel (0,0) reads address 1000 and the last cell reads 1767.
